// File: rtl/seg7_capture_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared types and constants for the 7-segment capture/scan block.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // Segment pattern, active-high, bit order {g,f,e,d,c,b,a}
   typedef logic [6:0] seg_t;

   // One display digit: pattern plus a flag saying it holds real data
   typedef struct packed {
      logic valid;
      seg_t pat;
   } digit_t;

   localparam seg_t       SEG_BLANK  = 7'h00;
   localparam logic [7:0] AN_OFF     = 8'hFF;
   localparam digit_t     DIGIT_NONE = '{valid: 1'b0, pat: SEG_BLANK};

endpackage
`default_nettype wire

// File: rtl/seg7_capture_scan_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scanner
// Brief    : Refresh divider, digit scan index and registered anode/cathode
//            drive for a common-anode multiplexed display.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DIGITS      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    display_on_i,
   input  digit_t [DIGITS-1:0]     digits_i,
   output logic [7:0]              s7_o,
   output logic [7:0]              an_o
);

   localparam int c_cnt_w = $clog2(REFRESH_DIV);
   localparam int c_idx_w = $clog2(DIGITS);

   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic [c_idx_w-1:0] idx_q, idx_d;
   logic [7:0]         s7_q, s7_d;
   logic [7:0]         an_q, an_d;
   logic               wrap;
   digit_t             cur;

   // Next-state for the refresh counter, scan index and output drive
   always_comb begin
      wrap  = (cnt_q == c_cnt_w'(REFRESH_DIV - 1));
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (wrap) begin
         idx_d = (idx_q == c_idx_w'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      cur  = digits_i[idx_q];
      s7_d = AN_OFF;
      an_d = AN_OFF;
      // Only the selected anode goes low; bits at or above DIGITS stay high
      // because idx_q never reaches them. The decimal point stays dark.
      if (display_on_i && cur.valid) begin
         an_d = AN_OFF & ~(8'h01 << idx_q);
         s7_d = {1'b1, ~cur.pat};
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
         s7_q  <= AN_OFF;
         an_q  <= AN_OFF;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         s7_q  <= s7_d;
         an_q  <= an_d;
      end
   end

   assign s7_o = s7_q;
   assign an_o = an_q;

endmodule
`default_nettype wire

// File: rtl/seg7_capture_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_capture_scan
// Brief    : Captures the processor's nibble-multiplexed 7-segment output on
//            proc_clk rising edges, keeps a history of recent bytes and scans
//            it onto an 8-digit common-anode display.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_capture_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DIGITS      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       proc_clk,
   input  logic [6:0] seg_in,
   input  logic       lsb_in,
   input  logic       display_on,
   input  logic       clear,
   output logic [7:0] s7,
   output logic [7:0] an
);

   // Synchronizer bundle layout: {proc_clk, lsb, seg[6:0]}
   logic [8:0] meta_q;
   logic [8:0] sync_q;
   logic       pclk_prev_q;
   logic       smp_vld_q;
   logic [7:0] smp_q;          // {lsb, seg}

   logic       last_vld_q, last_vld_d;
   logic [7:0] last_q,     last_d;
   digit_t     pend_q,     pend_d;
   digit_t [DIGITS-1:0] dig_q, dig_d;

   logic       smp_new;

   // Two-flop synchronizer, edge detect, and registered sample strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q      <= '0;
         sync_q      <= '0;
         pclk_prev_q <= 1'b0;
         smp_vld_q   <= 1'b0;
         smp_q       <= '0;
      end else begin
         meta_q      <= {proc_clk, lsb_in, seg_in};
         sync_q      <= meta_q;
         pclk_prev_q <= sync_q[8];
         smp_vld_q   <= sync_q[8] & ~pclk_prev_q;
         smp_q       <= sync_q[7:0];
      end
   end

   // Capture: drop repeats, park the high pattern, push {high, low} on a low
   always_comb begin
      last_vld_d = last_vld_q;
      last_d     = last_q;
      pend_d     = pend_q;
      dig_d      = dig_q;
      smp_new    = smp_vld_q && !(last_vld_q && (last_q == smp_q));
      if (clear) begin
         // Clear wins over a coincident sample, which is simply lost
         last_vld_d = 1'b0;
         pend_d     = DIGIT_NONE;
         for (int i = 0; i < DIGITS; i++) begin
            dig_d[i] = DIGIT_NONE;
         end
      end else if (smp_new) begin
         last_vld_d = 1'b1;
         last_d     = smp_q;
         if (!smp_q[7]) begin
            pend_d = '{valid: 1'b1, pat: smp_q[6:0]};
         end else begin
            for (int i = 2; i < DIGITS; i++) begin
               dig_d[i] = dig_q[i-2];
            end
            dig_d[1] = pend_q;
            dig_d[0] = '{valid: 1'b1, pat: smp_q[6:0]};
            pend_d   = DIGIT_NONE;
         end
      end
   end

   // Capture state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         last_vld_q <= 1'b0;
         last_q     <= '0;
         pend_q     <= DIGIT_NONE;
         dig_q      <= '0;
      end else begin
         last_vld_q <= last_vld_d;
         last_q     <= last_d;
         pend_q     <= pend_d;
         dig_q      <= dig_d;
      end
   end

   seg7_scanner #(
      .REFRESH_DIV (REFRESH_DIV),
      .DIGITS      (DIGITS)
   ) u_scanner (
      .clk          (clk),
      .rst          (rst),
      .display_on_i (display_on),
      .digits_i     (dig_q),
      .s7_o         (s7),
      .an_o         (an)
   );

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_capture_scan
// Brief    : Directed self-checking bench for seg7_capture_scan
//            (REFRESH_DIV=4, DIGITS=8, proc_clk period 16 clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_capture_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       proc_clk;
   logic [6:0] seg_in;
   logic       lsb_in;
   logic       display_on;
   logic       clear;
   logic [7:0] s7;
   logic [7:0] an;

   int n_chk  = 0;
   int n_pass = 0;

   // Expected digit contents, filled in by hand per test
   logic       e_val [8];
   logic [6:0] e_pat [8];

   always #5 clk = ~clk;

   seg7_capture_scan #(
      .REFRESH_DIV (4),
      .DIGITS      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_clk   (proc_clk),
      .seg_in     (seg_in),
      .lsb_in     (lsb_in),
      .display_on (display_on),
      .clear      (clear),
      .s7         (s7),
      .an         (an)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic exp_none();
      for (int k = 0; k < 8; k++) begin
         e_val[k] = 1'b0;
         e_pat[k] = 7'h00;
      end
   endtask

   task automatic exp_set(input int j, input logic [6:0] p);
      e_val[j] = 1'b1;
      e_pat[j] = p;
   endtask

   // One proc_clk period: data set with proc_clk low, rise halfway through
   task automatic send(input logic [6:0] pat, input logic lsb, input logic with_clr);
      seg_in   = pat;
      lsb_in   = lsb;
      proc_clk = 1'b0;
      repeat (8) @(negedge clk);
      if (with_clr) clear = 1'b1;
      proc_clk = 1'b1;
      repeat (8) @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
   endtask

   // Watch one full scan (32 clk) and tally how long each anode is lit
   task automatic scan_check(input string tag);
      int lit [8];
      int bad;
      int zc;
      int j;
      bad = 0;
      for (int k = 0; k < 8; k++) lit[k] = 0;
      repeat (32) begin
         @(negedge clk);
         if (an === 8'hFF) begin
            if (s7 !== 8'hFF) bad++;
         end else begin
            zc = 0;
            j  = 0;
            for (int k = 0; k < 8; k++) begin
               if (an[k] === 1'b0) begin
                  zc++;
                  j = k;
               end
            end
            if (zc != 1) bad++;
            else begin
               lit[j]++;
               if (!(e_val[j] && display_on) || (s7 !== {1'b1, ~e_pat[j]})) bad++;
            end
         end
      end
      chk({tag, "_bad"}, bad, 0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s_lit%0d", tag, k), lit[k], (e_val[k] && display_on) ? 4 : 0);
      end
   endtask

   initial begin
      int bad;
      rst        = 1'b1;
      proc_clk   = 1'b0;
      seg_in     = 7'h00;
      lsb_in     = 1'b0;
      display_on = 1'b1;
      clear      = 1'b0;
      exp_none();

      // Reset held 3 clk, then idle with no samples
      repeat (3) @(negedge clk);
      chk("rst_s7", s7, 8'hFF);
      chk("rst_an", an, 8'hFF);
      rst = 1'b0;
      bad = 0;
      repeat (64) begin
         @(negedge clk);
         if (s7 !== 8'hFF || an !== 8'hFF) bad++;
      end
      chk("idle_dark", bad, 0);

      // First pair: digit1 = 3F (s7 C0), digit0 = 06 (s7 F9)
      send(7'h3F, 1'b0, 1'b0);
      send(7'h06, 1'b1, 1'b0);
      exp_none();
      exp_set(1, 7'h3F);
      exp_set(0, 7'h06);
      scan_check("pair1");

      // Five pairs: oldest dropped, pairs 2..5 retained
      do_clear();
      send(7'h01, 1'b0, 1'b0); send(7'h11, 1'b1, 1'b0);
      send(7'h02, 1'b0, 1'b0); send(7'h12, 1'b1, 1'b0);
      send(7'h03, 1'b0, 1'b0); send(7'h13, 1'b1, 1'b0);
      send(7'h04, 1'b0, 1'b0); send(7'h14, 1'b1, 1'b0);
      send(7'h05, 1'b0, 1'b0); send(7'h15, 1'b1, 1'b0);
      exp_none();
      exp_set(7, 7'h02); exp_set(6, 7'h12);
      exp_set(5, 7'h03); exp_set(4, 7'h13);
      exp_set(3, 7'h04); exp_set(2, 7'h14);
      exp_set(1, 7'h05); exp_set(0, 7'h15);
      scan_check("five");

      // Repeated identical low sample pushes only once
      do_clear();
      send(7'h22, 1'b0, 1'b0);
      repeat (6) send(7'h33, 1'b1, 1'b0);
      exp_none();
      exp_set(1, 7'h22);
      exp_set(0, 7'h33);
      scan_check("dedup");

      // Low with nothing pending: digit1 invalid
      send(7'h44, 1'b1, 1'b0);
      exp_none();
      exp_set(3, 7'h22);
      exp_set(2, 7'h33);
      exp_set(0, 7'h44);
      scan_check("nohigh");

      // Clear coincident with a capture: everything invalid, no push
      send(7'h66, 1'b1, 1'b1);
      exp_none();
      scan_check("clrcap");
      send(7'h5A, 1'b0, 1'b0);
      send(7'h25, 1'b1, 1'b0);
      exp_set(1, 7'h5A);
      exp_set(0, 7'h25);
      scan_check("afterclr");

      // Fill the history, blank it, capture while blank, re-enable
      send(7'h61, 1'b0, 1'b0); send(7'h71, 1'b1, 1'b0);
      send(7'h62, 1'b0, 1'b0); send(7'h72, 1'b1, 1'b0);
      send(7'h63, 1'b0, 1'b0); send(7'h73, 1'b1, 1'b0);
      exp_none();
      exp_set(7, 7'h5A); exp_set(6, 7'h25);
      exp_set(5, 7'h61); exp_set(4, 7'h71);
      exp_set(3, 7'h62); exp_set(2, 7'h72);
      exp_set(1, 7'h63); exp_set(0, 7'h73);
      scan_check("full");
      display_on = 1'b0;
      scan_check("off");
      send(7'h64, 1'b0, 1'b0); send(7'h74, 1'b1, 1'b0);
      display_on = 1'b1;
      exp_none();
      exp_set(7, 7'h61); exp_set(6, 7'h71);
      exp_set(5, 7'h62); exp_set(4, 7'h72);
      exp_set(3, 7'h63); exp_set(2, 7'h73);
      exp_set(1, 7'h64); exp_set(0, 7'h74);
      scan_check("on");

      // Reset with a high byte pending: pending and history are lost
      send(7'h11, 1'b0, 1'b0);
      proc_clk = 1'b0;
      rst      = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstmid_s7", s7, 8'hFF);
      chk("rstmid_an", an, 8'hFF);
      rst = 1'b0;
      send(7'h12, 1'b1, 1'b0);
      exp_none();
      exp_set(0, 7'h12);
      scan_check("rstmid");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
